restador_serial_n_bits: RTL and testbench

// - Bit-serial N-bit subtractor: computes d = a - b - b_in, LSB first, one bit per clock.
// - Performs the inverse of the combinational N-bit adder.
// - Used where area matters more than latency.
// - Start/done handshake; results held stable until the next accepted start.

---
 rtl/restador_pkg.sv | 10 +
 rtl/restador_completo.sv | 13 +
 rtl/restador_serial_n_bits.sv | 142 ++++++++++++++
 tb/tb_restador_serial_n_bits.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/restador_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package restador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } estado_t;

endpackage : restador_pkg

// File: rtl/restador_completo.sv
// 1-bit full subtractor: x - y - bi, producing the difference bit and borrow-out.
module restador_completo (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic dif,
   output logic bo
);

   assign dif = x ^ y ^ bi;
   assign bo  = (~x & y) | (~(x ^ y) & bi);

endmodule : restador_completo

// File: rtl/restador_serial_n_bits.sv
// Bit-serial N-bit subtractor d = a - b - b_in, LSB first, one bit per clock,
// with a start/done handshake; results hold until the next accepted start.
module restador_serial_n_bits
   import restador_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         b_in,
   output logic [N-1:0] d,
   output logic         b_out,
   output logic         ovf,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   estado_t         estado_r;
   estado_t         estado_sig_s;
   logic [N-1:0]    a_sh_r;
   logic [N-1:0]    b_sh_r;
   logic [N-1:0]    d_sh_r;
   logic [N-1:0]    d_next_s;
   logic            borrow_r;
   logic [CW-1:0]   cnt_r;
   logic            a_msb_r;
   logic            b_msb_r;
   logic [N-1:0]    d_r;
   logic            b_out_r;
   logic            ovf_r;
   logic            busy_r;
   logic            done_r;
   logic            dif_s;
   logic            bo_s;
   logic            ultimo_s;

   restador_completo u_completo (
      .x   (a_sh_r[0]),
      .y   (b_sh_r[0]),
      .bi  (borrow_r),
      .dif (dif_s),
      .bo  (bo_s)
   );

   // The newest difference bit enters from the MSB side; works for N=1 too.
   assign d_next_s = N'({dif_s, d_sh_r} >> 1'b1);
   assign ultimo_s = (cnt_r == CW'(N - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_r <= IDLE;
      end else begin
         estado_r <= estado_sig_s;
      end
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      estado_sig_s = estado_r;
      case (estado_r)
         IDLE: begin
            if (start) begin
               estado_sig_s = RUN;
            end else begin
               estado_sig_s = IDLE;
            end
         end
         RUN: begin
            if (ultimo_s) begin
               estado_sig_s = DONE;
            end else begin
               estado_sig_s = RUN;
            end
         end
         DONE:    estado_sig_s = IDLE;
         default: estado_sig_s = IDLE;
      endcase
   end

   // Operand capture, serial datapath, result register and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         d_sh_r   <= '0;
         borrow_r <= 1'b0;
         cnt_r    <= '0;
         a_msb_r  <= 1'b0;
         b_msb_r  <= 1'b0;
         d_r      <= '0;
         b_out_r  <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (estado_r)
            IDLE: begin
               if (start) begin
                  a_sh_r   <= a;
                  b_sh_r   <= b;
                  borrow_r <= b_in;
                  cnt_r    <= '0;
                  a_msb_r  <= a[N-1];
                  b_msb_r  <= b[N-1];
               end
            end
            RUN: begin
               a_sh_r   <= a_sh_r >> 1'b1;
               b_sh_r   <= b_sh_r >> 1'b1;
               borrow_r <= bo_s;
               d_sh_r   <= d_next_s;
               if (ultimo_s) begin
                  // Publish the whole result at once so d never shows partial bits.
                  d_r     <= d_next_s;
                  b_out_r <= bo_s;
                  ovf_r   <= (a_msb_r ^ b_msb_r) & (dif_s ^ a_msb_r);
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
         busy_r <= (estado_sig_s == RUN);
         done_r <= (estado_sig_s == DONE);
      end
   end

   assign d     = d_r;
   assign b_out = b_out_r;
   assign ovf   = ovf_r;
   assign busy  = busy_r;
   assign done  = done_r;

endmodule : restador_serial_n_bits

// File: tb/tb_restador_serial_n_bits.sv
// Scoreboard bench for restador_serial_n_bits (N=8): expected results are queued
// at start and compared whenever done pulses.
module tb_restador_serial_n_bits;

   localparam int N = 8;

   typedef struct {
      logic [N-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a_i;
   logic [N-1:0] b_i;
   logic         b_in_i;
   logic [N-1:0] d_o;
   logic         b_out_o;
   logic         ovf_o;
   logic         busy_o;
   logic         done_o;

   exp_t sb[$];
   int   errors;
   int   checks;
   int   done_cnt;
   int   lat;
   int   bcyc;

   restador_serial_n_bits #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .b_in  (b_in_i),
      .d     (d_o),
      .b_out (b_out_o),
      .ovf   (ovf_o),
      .busy  (busy_o),
      .done  (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
      exp_t       e;
      logic [N:0] full;
      full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
      e.d  = full[N-1:0];
      e.bo = full[N];
      e.ov = (x[N-1] != y[N-1]) && (e.d[N-1] != x[N-1]);
      return e;
   endfunction

   // Scoreboard: compare every done pulse against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done_o === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check_val("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("d", d_o, e.d);
            check_val("b_out", b_out_o, e.bo);
            check_val("ovf", ovf_o, e.ov);
         end
      end
   end

   task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi, input bit push);
      @(negedge clk);
      a_i    = x;
      b_i    = y;
      b_in_i = bi;
      start  = 1'b1;
      if (push) sb.push_back(model(x, y, bi));
      @(posedge clk);
      #1;
      start  = 1'b0;
      a_i    = N'($urandom);
      b_i    = N'($urandom);
      b_in_i = 1'($urandom);
   endtask

   // Called #1 after the accepting edge; counts edges inclusive of that edge.
   task automatic wait_done(output int l, output int bc);
      l  = 1;
      bc = (busy_o === 1'b1) ? 1 : 0;
      while (done_o !== 1'b1 && l < 40) begin
         @(posedge clk);
         #1;
         l++;
         if (busy_o === 1'b1) bc++;
      end
      if (done_o !== 1'b1) check_val("timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      check_val("done_one_cycle", done_o, 1'b0);
   endtask

   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
      start_op(x, y, bi, 1'b1);
      wait_done(lat, bcyc);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      done_cnt = 0;
      rst      = 1'b1;
      start    = 1'b0;
      a_i      = '0;
      b_i      = '0;
      b_in_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_d", d_o, 8'h00);
      check_val("rst_b_out", b_out_o, 1'b0);
      check_val("rst_ovf", ovf_o, 1'b0);
      check_val("rst_busy", busy_o, 1'b0);
      check_val("rst_done", done_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'h05, 8'h03, 1'b0);
      check_val("latency", lat, N + 1);
      check_val("busy_cycles", bcyc, N);
      run_op(8'h00, 8'h01, 1'b0);
      run_op(8'h80, 8'h01, 1'b0);
      run_op(8'h10, 8'h05, 1'b1);
      run_op(8'h00, 8'hFF, 1'b1);
      check_val("hold_d", d_o, 8'h00);

      // A start pulse mid-run must not disturb the operation in flight.
      start_op(8'h0A, 8'h04, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      a_i   = 8'hFF;
      b_i   = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("busy_mid", busy_o, 1'b1);
      wait_done(lat, bcyc);
      repeat (3) @(posedge clk);
      #1;
      check_val("no_restart", busy_o, 1'b0);

      // Reset mid-run aborts immediately with no done pulse.
      start_op(8'h33, 8'h11, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("abort_d", d_o, 8'h00);
      check_val("abort_busy", busy_o, 1'b0);
      check_val("abort_done", done_o, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 3) @(posedge clk);
      #1;
      check_val("abort_idle", busy_o, 1'b0);
      run_op(8'h09, 8'h09, 1'b0);

      for (int i = 0; i < 4; i++) begin
         run_op(N'($urandom), N'($urandom), 1'($urandom));
      end

      repeat (2) @(posedge clk);
      check_val("sb_empty", sb.size(), 32'd0);
      check_val("done_count", done_cnt, 32'd11);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_restador_serial_n_bits
